// File: rtl/req_issuer_if.sv
// -----------------------------------------------------------------------------
// req_issuer_if
// Handshake and data bundle between an upstream requester, the req_issuer
// block, and the downstream memory stage.
//   req_valid/req_ready/req_addr/req_data : upstream request channel
//   mem_addr/mem_data/mem_ready/mem_rdata : memory stage channel
//   rsp_valid/rsp_data                    : one-cycle response strobe + word
// The slave modport is the issuer's view; the master modport is the
// environment's view (requester and memory stage together).
// -----------------------------------------------------------------------------
interface req_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_data, mem_ready, mem_rdata,
        input  req_ready, mem_addr, mem_data, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, mem_ready, mem_rdata,
        output req_ready, mem_addr, mem_data, rsp_valid, rsp_data
    );
endinterface

// File: rtl/req_issuer.sv
// -----------------------------------------------------------------------------
// req_issuer
// Buffers upstream {addr, data} requests in a small FIFO and issues them one
// at a time to a memory stage through a three-state FSM
// (IDLE -> ISSUE -> WAIT_DATA -> IDLE). Each completed transaction produces a
// single-cycle rsp_valid pulse with the captured read word on rsp_data.
//
// Parameters:
//   FIFO_DEPTH : request buffer entries (power of two, 2..16)
//   TIMEOUT    : cycles ISSUE may wait for mem_ready (timeout build only)
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   bus         : req_issuer_if.slave (request, memory and response channels)
//   busy        : FSM not in IDLE or buffer not empty
//   timeout_err : sticky timeout flag
//
// Build option: define REQ_TIMEOUT_EN to abandon a transaction after TIMEOUT
// cycles in ISSUE without mem_ready; the block then sets timeout_err, returns
// 32'hDEAD_DEAD as the response word and goes back to IDLE. Without the macro
// ISSUE waits indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module req_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         reset,
    req_issuer_if.slave  bus,
    output logic         busy,
    output logic         timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Reject illegal configurations at elaboration time.
    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
        $error("req_issuer: FIFO_DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    logic [47:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    state_t           state_r;
    logic [15:0]      mem_addr_r;
    logic [31:0]      mem_data_r;
    logic [31:0]      rsp_data_r;
    logic             rsp_valid_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

`ifdef REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;
`endif

    // FIFO status and handshake qualification; the pop only happens from IDLE.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {CNT_W{1'b0}});
        // A push is refused when full even if a pop happens this cycle.
        push_s  = bus.req_valid && !full_s;
        pop_s   = (state_r == ST_IDLE) && !empty_s;
    end

    assign bus.req_ready = !full_s;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_data  = mem_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign busy          = (state_r != ST_IDLE) || !empty_s;

`ifdef REQ_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Request storage; contents are only read while the count says valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.req_addr, bus.req_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            mem_addr_r    <= 16'h0000;
            mem_data_r    <= 32'h0000_0000;
            rsp_data_r    <= 32'h0000_0000;
            rsp_valid_r   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            tmo_cnt_r     <= {TMO_W{1'b0}};
            timeout_err_r <= 1'b0;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        {mem_addr_r, mem_data_r} <= fifo_mem_r[rd_ptr_r];
                        state_r <= ST_ISSUE;
`ifdef REQ_TIMEOUT_EN
                        tmo_cnt_r <= {TMO_W{1'b0}};
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // mem_addr/mem_data are simply not written here, so they stay stable.
                    if (bus.mem_ready) begin
                        state_r <= ST_WAIT_DATA;
`ifdef REQ_TIMEOUT_EN
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
                        // TIMEOUT-th ISSUE cycle without mem_ready: abandon it.
                        timeout_err_r <= 1'b1;
                        rsp_data_r    <= 32'hDEAD_DEAD;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                        state_r   <= ST_ISSUE;
                    end
`else
                    end else begin
                        state_r <= ST_ISSUE;
                    end
`endif
                end
                ST_WAIT_DATA: begin
                    // Read word arrives the cycle after mem_ready; mem_ready is ignored here.
                    rsp_data_r  <= bus.mem_rdata;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_issuer.sv
// -----------------------------------------------------------------------------
// tb_req_issuer
// Directed self-checking bench for req_issuer (FIFO_DEPTH=4, TIMEOUT=16).
// A scoreboard queue receives the expected response word when a request is
// handed to the DUT; a negedge monitor pops and compares on every rsp_valid.
// The memory stage is modelled by a combinational function of mem_addr/data.
// -----------------------------------------------------------------------------
module tb_req_issuer;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic timeout_err;

    req_issuer_if bus ();

    req_issuer #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          rsp_cnt = 0;
    longint      cyc = 0;
    logic [31:0] exp_q[$];
    longint      rsp_cyc_q[$];

    // Memory stage model: fixed word for the reference request, else a mix of addr/data.
    function automatic logic [31:0] rdata_fn(input logic [15:0] a, input logic [31:0] d);
        if ((a == 16'h0010) && (d == 32'h1234_5678)) return 32'hCAFE_F00D;
        return d ^ {a, ~a};
    endfunction

    assign bus.mem_rdata = rdata_fn(bus.mem_addr, bus.mem_data);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter used to measure response spacing.
    always @(posedge clk) cyc <= cyc + 64'd1;

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_cyc_q.push_back(cyc);
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
        end
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        while (bus.req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (bus.req_ready === 1'b1) begin
            exp_q.push_back(e);
            tick();
        end else begin
            chk("push_accepted", 64'(bus.req_ready), 64'd1);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_data  = 32'h0000_0000;
        bus.mem_ready = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_data", 64'(bus.mem_data), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        reset = 1'b1;
        tick();

        // Single request, mem_ready two cycles into ISSUE
        push(16'h0010, 32'h1234_5678, rdata_fn(16'h0010, 32'h1234_5678));
        tick();                                   // popped, now ISSUE
        chk("single_mem_addr", 64'(bus.mem_addr), 64'h0010);
        chk("single_mem_data", 64'(bus.mem_data), 64'h1234_5678);
        chk("single_busy", 64'(busy), 64'd1);
        tick();
        bus.mem_ready = 1'b1;
        tick();                                   // mem_ready sampled
        bus.mem_ready = 1'b0;
        chk("single_no_early_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("single_addr_stable", 64'(bus.mem_addr), 64'h0010);
        tick();
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_rsp_data", 64'(bus.rsp_data), 64'hCAFE_F00D);
        tick();
        chk("single_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("single_rsp_hold", 64'(bus.rsp_data), 64'hCAFE_F00D);

        // Four back-to-back requests with mem_ready held high
        rsp_cyc_q.delete();
        bus.mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++)
            push(16'(i), 32'hA000_0000 + 32'(i), rdata_fn(16'(i), 32'hA000_0000 + 32'(i)));
        wait_idle(100);
        bus.mem_ready = 1'b0;
        chk("b2b_rsp_count", 64'(rsp_cyc_q.size()), 64'd4);
        for (int i = 1; i < 4; i++)
            if (rsp_cyc_q.size() > i) chk("b2b_spacing", 64'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 64'd3);

        // Fill: one in flight plus four buffered, then a stalled sixth push
        base = rsp_cnt;
        for (int i = 0; i < 5; i++)
            push(16'h0020 + 16'(i), 32'hB000_0000 + 32'(i), rdata_fn(16'h0020 + 16'(i), 32'hB000_0000 + 32'(i)));
        chk("full_req_ready", 64'(bus.req_ready), 64'd0);
        chk("full_count", 64'(dut.count_r), 64'd4);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0025;
        bus.req_data  = 32'hB000_0005;
        repeat (3) tick();
        chk("full_stall", 64'(bus.req_ready), 64'd0);
        bus.mem_ready = 1'b1;
        push(16'h0025, 32'hB000_0005, rdata_fn(16'h0025, 32'hB000_0005));
        wait_idle(200);
        bus.mem_ready = 1'b0;
        chk("full_all_rsp", 64'(rsp_cnt - base), 64'd6);

        // Push and pop in the same cycle at count 2
        push(16'h0030, 32'hC000_0000, rdata_fn(16'h0030, 32'hC000_0000));
        push(16'h0031, 32'hC000_0001, rdata_fn(16'h0031, 32'hC000_0001));
        push(16'h0032, 32'hC000_0002, rdata_fn(16'h0032, 32'hC000_0002));
        chk("pp_count_before", 64'(dut.count_r), 64'd2);
        bus.mem_ready = 1'b1;
        tick();                                   // ISSUE -> WAIT_DATA
        bus.mem_ready = 1'b0;
        tick();                                   // WAIT_DATA -> IDLE
        chk("pp_count_idle", 64'(dut.count_r), 64'd2);
        chk("pp_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0033;
        bus.req_data  = 32'hC000_0003;
        exp_q.push_back(rdata_fn(16'h0033, 32'hC000_0003));
        tick();                                   // pop and push together
        bus.req_valid = 1'b0;
        chk("pp_count_after", 64'(dut.count_r), 64'd2);
        chk("pp_ready_after", 64'(bus.req_ready), 64'd1);
        bus.mem_ready = 1'b1;
        wait_idle(200);
        bus.mem_ready = 1'b0;

`ifdef REQ_TIMEOUT_EN
        // Timeout after 16 ISSUE cycles, then a normal request
        push(16'h0040, 32'h4444_4444, 32'hDEAD_DEAD);
        tick();                                   // now ISSUE
        repeat (15) tick();
        chk("tmo_not_yet", 64'(timeout_err), 64'd0);
        chk("tmo_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("tmo_err", 64'(timeout_err), 64'd1);
        chk("tmo_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("tmo_rsp_data", 64'(bus.rsp_data), 64'hDEAD_DEAD);
        bus.mem_ready = 1'b1;
        push(16'h0041, 32'h4444_4445, rdata_fn(16'h0041, 32'h4444_4445));
        wait_idle(100);
        bus.mem_ready = 1'b0;
        chk("tmo_sticky", 64'(timeout_err), 64'd1);
`else
        // Without the timeout build ISSUE waits indefinitely
        base = rsp_cnt;
        push(16'h0040, 32'h4444_4444, rdata_fn(16'h0040, 32'h4444_4444));
        repeat (40) tick();
        chk("notmo_err", 64'(timeout_err), 64'd0);
        chk("notmo_busy", 64'(busy), 64'd1);
        chk("notmo_no_rsp", 64'(rsp_cnt - base), 64'd0);
        bus.mem_ready = 1'b1;
        wait_idle(100);
        bus.mem_ready = 1'b0;
        chk("notmo_err_end", 64'(timeout_err), 64'd0);
`endif

        // Reset in ISSUE with two entries queued
        push(16'h0050, 32'h5555_0000, rdata_fn(16'h0050, 32'h5555_0000));
        push(16'h0051, 32'h5555_0001, rdata_fn(16'h0051, 32'h5555_0001));
        push(16'h0052, 32'h5555_0002, rdata_fn(16'h0052, 32'h5555_0002));
        tick();
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("mid_rst_mem_data", 64'(bus.mem_data), 64'd0);
        chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) tick();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        base = rsp_cnt;
        repeat (10) tick();
        chk("mid_rst_no_rsp", 64'(rsp_cnt - base), 64'd0);
        chk("mid_rst_idle", 64'(busy), 64'd0);
        bus.mem_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
